// File: rtl/regfile_vector.sv
// Vector register file for the decode stage: NUM_REGS x LANES x DATA_W storage with
// per-lane masked writeback, same-cycle write-to-read bypass and a RAW scoreboard.

module regfile_vector_lane #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              re1,
    input  logic              re2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // re* is low for the hardwired zero register and out-of-range addresses.
    assign rd1 = !re1 ? '0 : (we && wa == ra1) ? wd : mem[ra1];
    assign rd2 = !re2 ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

module regfile_vector #(
    parameter int  DATA_W   = 16,
    parameter int  LANES    = 4,
    parameter int  NUM_REGS = 16,
    parameter bit  ZERO_REG = 1'b1,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       a1,
    input  logic [ADDR_W-1:0]       a2,
    input  logic [ADDR_W-1:0]       a3,
    input  logic                    wre,
    input  logic [LANES*DATA_W-1:0] wd3,
    input  logic [LANES-1:0]        lane_mask,
    output logic [LANES*DATA_W-1:0] rd1,
    output logic [LANES*DATA_W-1:0] rd2,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_dst,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    hazard,
    output logic [ADDR_W:0]         busy_count
);
    localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W+1)'(NUM_REGS);

    // Address names a real, writable register.
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_EXT) && !(ZERO_REG && a == '0);
    endfunction

    logic [LANES-1:0][DATA_W-1:0] wd_l, rd1_l, rd2_l;
    logic                         wr_live, iss_live, re1, re2;
    logic [NUM_REGS-1:0]          busy, busy_nxt;

    assign wd_l     = wd3;
    assign rd1      = rd1_l;
    assign rd2      = rd2_l;
    assign wr_live  = !reset && wre && live(a3);
    assign iss_live = !reset && issue_valid && live(issue_dst);
    assign re1      = live(a1);
    assign re2      = live(a2);

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        regfile_vector_lane #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .we   (wr_live && lane_mask[i]),
            .wa   (a3),
            .wd   (wd_l[i]),
            .ra1  (a1),
            .ra2  (a2),
            .re1  (re1),
            .re2  (re2),
            .rd1  (rd1_l[i]),
            .rd2  (rd2_l[i])
        );
    end

    // Clear before set so a new producer issued alongside writeback wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_live)  busy_nxt[a3]        = 1'b0;
        if (iss_live) busy_nxt[issue_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    // A writeback this cycle satisfies the hazard since the bypass forwards it.
    assign busy1  = re1 && busy[a1] && !(wre && a3 == a1);
    assign busy2  = re2 && busy[a2] && !(wre && a3 == a2);
    assign hazard = busy1 | busy2;

    always_comb begin
        busy_count = '0;
        for (int r = 0; r < NUM_REGS; r++) busy_count += (ADDR_W+1)'(busy[r]);
    end
endmodule

// File: tb/tb_regfile_vector.sv
// Bench for regfile_vector: directed scenarios plus randomized traffic against a
// behavioural model of register contents and in-flight destinations.

module tb_regfile_vector;
    logic        clk = 1'b0;
    logic        reset, wre, issue_valid;
    logic [3:0]  a1, a2, a3, issue_dst, lane_mask;
    logic [63:0] wd3, rd1, rd2;
    logic        busy1, busy2, hazard;
    logic [4:0]  busy_count;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] m_reg [16][4];
    bit          m_busy [16];

    regfile_vector dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .wre(wre),
        .wd3(wd3), .lane_mask(lane_mask), .rd1(rd1), .rd2(rd2),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .busy1(busy1), .busy2(busy2), .hazard(hazard), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_rd(input logic [3:0] a);
        logic [63:0] r;
        for (int l = 0; l < 4; l++)
            r[l*16 +: 16] = (wre && a3 == a && lane_mask[l]) ? wd3[l*16 +: 16] : m_reg[a][l];
        if (a == 4'd0) r = '0;
        return r;
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        return (a != 4'd0) && m_busy[a] && !(wre && a3 == a);
    endfunction

    function automatic logic [4:0] exp_count();
        int c = 0;
        for (int r = 0; r < 16; r++) c += int'(m_busy[r]);
        return 5'(c);
    endfunction

    // Apply the current inputs to the model, then advance the DUT one edge.
    task automatic tick();
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                m_busy[r] = 1'b0;
                for (int l = 0; l < 4; l++) m_reg[r][l] = '0;
            end
        end else begin
            if (wre && a3 != 4'd0)
                for (int l = 0; l < 4; l++)
                    if (lane_mask[l]) m_reg[a3][l] = wd3[l*16 +: 16];
            if (wre) m_busy[a3] = 1'b0;
            if (issue_valid && issue_dst != 4'd0) m_busy[issue_dst] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; wre = 0; issue_valid = 0; lane_mask = '0; wd3 = '0;
        a3 = '0; issue_dst = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; wre = 1; a3 = 4'd3; wd3 = '1; lane_mask = 4'hF;
        issue_valid = 1; issue_dst = 4'd7;
        tick();
        idle(); a1 = 4'd3; a2 = 4'd7; #1;
        n_total++; if (rd1 !== 64'd0) $display("FAIL reset_rd1 got %h want 0", rd1); else n_pass++;
        n_total++; if (rd2 !== 64'd0) $display("FAIL reset_rd2 got %h want 0", rd2); else n_pass++;
        n_total++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", hazard); else n_pass++;
        n_total++; if (busy_count !== 5'd0) $display("FAIL reset_count got %0d want 0", busy_count); else n_pass++;
    endtask

    task automatic test_masked_write();
        idle(); wre = 1; a3 = 4'd5; wd3 = 64'h4444_3333_2222_1111; lane_mask = 4'b0101;
        tick();
        idle(); a1 = 4'd5; #1;
        n_total++;
        if (rd1 !== 64'h0000_3333_0000_1111) $display("FAIL masked_write got %h want 0000333300001111", rd1);
        else n_pass++;
        wre = 1; a3 = 4'd5; wd3 = 64'h8888_7777_6666_5555; lane_mask = 4'b1010;
        tick();
        idle(); a1 = 4'd5; #1;
        n_total++;
        if (rd1 !== 64'h8888_3333_6666_1111) $display("FAIL masked_merge got %h want 8888333366661111", rd1);
        else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); wre = 1; a3 = 4'd2; wd3 = 64'hAAAA_BBBB_CCCC_DDDD; lane_mask = 4'hF;
        a1 = 4'd2; a2 = 4'd2; #1;
        n_total++; if (rd1 !== 64'hAAAA_BBBB_CCCC_DDDD) $display("FAIL bypass_rd1 got %h want AAAABBBBCCCCDDDD", rd1); else n_pass++;
        n_total++; if (rd2 !== 64'hAAAA_BBBB_CCCC_DDDD) $display("FAIL bypass_rd2 got %h want AAAABBBBCCCCDDDD", rd2); else n_pass++;
        tick();
        wd3 = 64'h1234_5678_9ABC_DEF0; lane_mask = 4'b0011; #1;
        n_total++; if (rd1 !== 64'hAAAA_BBBB_9ABC_DEF0) $display("FAIL bypass_partial got %h want AAAABBBB9ABCDEF0", rd1); else n_pass++;
        tick();
    endtask

    task automatic test_zero_reg();
        idle(); wre = 1; a3 = 4'd0; wd3 = '1; lane_mask = 4'hF;
        issue_valid = 1; issue_dst = 4'd0; a1 = 4'd0; #1;
        n_total++; if (rd1 !== 64'd0) $display("FAIL zero_bypass got %h want 0", rd1); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL zero_busy1 got %b want 0", busy1); else n_pass++;
        tick();
        idle(); a1 = 4'd0; #1;
        n_total++; if (rd1 !== 64'd0) $display("FAIL zero_read got %h want 0", rd1); else n_pass++;
        n_total++; if (busy_count !== 5'd0) $display("FAIL zero_count got %0d want 0", busy_count); else n_pass++;
    endtask

    task automatic test_scoreboard_raw();
        idle(); issue_valid = 1; issue_dst = 4'd4;
        tick();
        idle(); a1 = 4'd4; a2 = 4'd1; #1;
        n_total++; if (busy_count !== 5'd1) $display("FAIL raw_count got %0d want 1", busy_count); else n_pass++;
        n_total++; if (busy1 !== 1'b1) $display("FAIL raw_busy1 got %b want 1", busy1); else n_pass++;
        n_total++; if (hazard !== 1'b1) $display("FAIL raw_hazard got %b want 1", hazard); else n_pass++;
        tick(); tick();
        wre = 1; a3 = 4'd4; lane_mask = '0; #1;
        n_total++; if (busy1 !== 1'b0) $display("FAIL raw_wb_busy1 got %b want 0", busy1); else n_pass++;
        n_total++; if (hazard !== 1'b0) $display("FAIL raw_wb_hazard got %b want 0", hazard); else n_pass++;
        tick();
        idle(); #1;
        n_total++; if (busy_count !== 5'd0) $display("FAIL raw_clear_count got %0d want 0", busy_count); else n_pass++;
    endtask

    task automatic test_set_clear();
        idle(); issue_valid = 1; issue_dst = 4'd6;
        tick();
        wre = 1; a3 = 4'd6; lane_mask = 4'hF; wd3 = 64'h5;
        issue_valid = 1; issue_dst = 4'd6; a2 = 4'd6; #1;
        n_total++; if (busy2 !== 1'b0) $display("FAIL setclr_bypass_busy2 got %b want 0", busy2); else n_pass++;
        tick();
        idle(); a2 = 4'd6; #1;
        n_total++; if (busy2 !== 1'b1) $display("FAIL setclr_busy2 got %b want 1", busy2); else n_pass++;
        n_total++; if (busy_count !== 5'd1) $display("FAIL setclr_count got %0d want 1", busy_count); else n_pass++;
        reset = 1;
        tick();
        idle(); a2 = 4'd6; #1;
        n_total++; if (busy_count !== 5'd0) $display("FAIL setclr_reset_count got %0d want 0", busy_count); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL setclr_reset_busy2 got %b want 0", busy2); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            a1 = 4'($urandom_range(0, 15)); a2 = 4'($urandom_range(0, 15));
            a3 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
            wre = $urandom_range(0, 1) == 1;
            wd3 = {$urandom, $urandom}; lane_mask = 4'($urandom_range(0, 15));
            issue_valid = $urandom_range(0, 2) != 0;
            issue_dst = 4'($urandom_range(0, 15));
            #1;
            n_total++;
            if (busy_count !== exp_count()) $display("FAIL rnd_count cyc %0d got %0d want %0d", n, busy_count, exp_count());
            else n_pass++;
            if (!reset) begin
                n_total++;
                if (rd1 !== exp_rd(a1)) $display("FAIL rnd_rd1 cyc %0d a1=%0d got %h want %h", n, a1, rd1, exp_rd(a1));
                else n_pass++;
                n_total++;
                if (rd2 !== exp_rd(a2)) $display("FAIL rnd_rd2 cyc %0d a2=%0d got %h want %h", n, a2, rd2, exp_rd(a2));
                else n_pass++;
                n_total++;
                if ({busy1, busy2, hazard} !== {exp_busy(a1), exp_busy(a2), exp_busy(a1) | exp_busy(a2)})
                    $display("FAIL rnd_busy cyc %0d got %b%b%b want %b%b%b", n, busy1, busy2, hazard,
                             exp_busy(a1), exp_busy(a2), exp_busy(a1) | exp_busy(a2));
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        idle(); a1 = '0; a2 = '0; reset = 1;
        tick();
        test_reset();
        test_masked_write();
        test_bypass();
        test_zero_reg();
        test_scoreboard_raw();
        test_set_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
